// File: rtl/wb2axi_resp_unit.sv
// WB->AXI bridge return path: orders AXI B/R responses back onto Wishbone ack/err/data.
// Optional WB2AXI_RESP_ERR_EN maps SLVERR/DECERR responses to wb_err_o.
module wb2axi_resp_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned LOG_OUTSTANDING = $clog2(MAX_OUTSTANDING)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  input  logic                       req_we_i,
  output logic                       req_ready_o,
  input  logic                       axi_bvalid_i,
  input  logic [1:0]                 axi_bresp_i,
  output logic                       axi_bready_o,
  input  logic                       axi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      axi_rdata_i,
  input  logic [1:0]                 axi_rresp_i,
  input  logic                       axi_rlast_i,
  output logic                       axi_rready_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic [DATA_WIDTH-1:0]      wb_dat_o,
  output logic [LOG_OUTSTANDING:0]   outstanding_o,
  output logic                       proto_err_o
);

  localparam logic [LOG_OUTSTANDING-1:0] PTR_ONE  = LOG_OUTSTANDING'(1);
  localparam logic [LOG_OUTSTANDING:0]   CNT_ONE  = (LOG_OUTSTANDING+1)'(1);
  localparam logic [LOG_OUTSTANDING:0]   CNT_FULL = (LOG_OUTSTANDING+1)'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] we_q;
  logic [LOG_OUTSTANDING-1:0] wr_ptr_q;
  logic [LOG_OUTSTANDING-1:0] rd_ptr_q;
  logic [LOG_OUTSTANDING:0]   count_q;
  logic                       err_q;

  logic not_empty;
  logic head_we;
  logic b_hs;
  logic r_hs;
  logic pop;
  logic push;
  logic resp_err;

  assign not_empty    = (count_q != '0);
  assign head_we      = we_q[rd_ptr_q];
  assign req_ready_o  = (count_q != CNT_FULL);
  assign axi_bready_o = not_empty && head_we;
  assign axi_rready_o = not_empty && !head_we;

  assign b_hs = axi_bvalid_i && axi_bready_o;
  assign r_hs = axi_rvalid_i && axi_rready_o;
  assign pop  = b_hs || r_hs;
  assign push = req_valid_i && req_ready_o;

`ifdef WB2AXI_RESP_ERR_EN
  logic [1:0] resp_sel;
  assign resp_sel = b_hs ? axi_bresp_i : axi_rresp_i;
  // SLVERR and DECERR both carry bit 1 set
  assign resp_err = pop && resp_sel[1];
`else
  logic resp_unused;
  assign resp_unused = ^{axi_bresp_i, axi_rresp_i};
  assign resp_err    = 1'b0;
`endif

  assign outstanding_o = count_q;
  assign wb_err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wb_ack_o    <= 1'b0;
      err_q       <= 1'b0;
      wb_dat_o    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (push) begin
        we_q[wr_ptr_q] <= req_we_i;
        wr_ptr_q       <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      wb_ack_o <= pop && !resp_err;
      err_q    <= resp_err;
      if (r_hs) begin
        wb_dat_o <= axi_rdata_i;
        if (!axi_rlast_i) begin
          proto_err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb2axi_resp_unit.sv
// Bench for wb2axi_resp_unit: directed vector table, hand sequences, and a
// queue-based random reference model of in-order response completion.
module tb_wb2axi_resp_unit;

`ifdef WB2AXI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int unsigned MAXO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_we_i, req_ready_o;
  logic        axi_bvalid_i, axi_bready_o;
  logic [1:0]  axi_bresp_i;
  logic        axi_rvalid_i, axi_rlast_i, axi_rready_o;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic [2:0]  outstanding_o;
  logic        proto_err_o;

  wb2axi_resp_unit #(.DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_ready_o(req_ready_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bready_o(axi_bready_o),
    .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rv, we, bv;
    logic [1:0]  br;
    logic        rvl;
    logic [31:0] rd;
    logic        e_rdy, e_br, e_rr, e_ack, e_err;
    logic [2:0]  e_cnt;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[34];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A1 = 32'hA1A1_0001;
  localparam logic [31:0] A2 = 32'hA2A2_0002;

  function automatic vec_t mk(logic rv, logic we, logic bv, logic [1:0] br, logic rvl,
                              logic [31:0] rd, logic e_rdy, logic e_br, logic e_rr,
                              logic e_ack, logic e_err, logic [2:0] e_cnt, logic [31:0] e_dat);
    vec_t v;
    v.rv = rv; v.we = we; v.bv = bv; v.br = br; v.rvl = rvl; v.rd = rd;
    v.e_rdy = e_rdy; v.e_br = e_br; v.e_rr = e_rr; v.e_ack = e_ack; v.e_err = e_err;
    v.e_cnt = e_cnt; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic we, input logic bv, input logic [1:0] br,
                       input logic rvl, input logic [31:0] rd, input logic rl);
    req_valid_i  = rv;  req_we_i    = we;
    axi_bvalid_i = bv;  axi_bresp_i = br;
    axi_rvalid_i = rvl; axi_rdata_i = rd; axi_rlast_i = rl; axi_rresp_i = 2'b00;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ack"},   {31'd0, wb_ack_o}, 32'd0);
    chk({tag, " err"},   {31'd0, wb_err_o}, 32'd0);
    chk({tag, " dat"},   wb_dat_o, 32'd0);
    chk({tag, " proto"}, {31'd0, proto_err_o}, 32'd0);
    chk({tag, " ready"}, {31'd0, req_ready_o}, 32'd1);
    chk({tag, " bready"},{31'd0, axi_bready_o}, 32'd0);
    chk({tag, " rready"},{31'd0, axi_rready_o}, 32'd0);
    chk({tag, " cnt"},   {29'd0, outstanding_o}, 32'd0);
  endtask

  // random-phase reference model state
  bit          q[$];
  logic        m_ack, m_err, m_proto;
  logic [31:0] m_dat;

  initial begin
    tbl[0]  = mk(1,1,0,0,0,0,   1,0,0,0,0,0,0);
    tbl[1]  = mk(0,0,1,0,0,0,   1,1,0,0,0,1,0);
    tbl[2]  = mk(0,0,0,0,0,0,   1,0,0,1,0,0,0);
    tbl[3]  = mk(1,0,0,0,0,0,   1,0,0,0,0,0,0);
    tbl[4]  = mk(0,0,0,0,1,DB,  1,0,1,0,0,1,0);
    tbl[5]  = mk(0,0,0,0,0,0,   1,0,0,1,0,0,DB);
    tbl[6]  = mk(0,0,0,0,0,0,   1,0,0,0,0,0,DB);
    tbl[7]  = mk(1,1,0,0,0,0,   1,0,0,0,0,0,DB);
    tbl[8]  = mk(1,0,0,0,0,0,   1,1,0,0,0,1,DB);
    tbl[9]  = mk(1,1,0,0,0,0,   1,1,0,0,0,2,DB);
    tbl[10] = mk(1,0,0,0,0,0,   1,1,0,0,0,3,DB);
    tbl[11] = mk(0,0,0,0,1,A1,  0,1,0,0,0,4,DB);
    tbl[12] = mk(0,0,1,0,1,A1,  0,1,0,0,0,4,DB);
    tbl[13] = mk(0,0,1,0,1,A1,  1,0,1,1,0,3,DB);
    tbl[14] = mk(0,0,1,0,1,A1,  1,1,0,1,0,2,A1);
    tbl[15] = mk(0,0,1,0,1,A2,  1,0,1,1,0,1,A1);
    tbl[16] = mk(0,0,0,0,0,0,   1,0,0,1,0,0,A2);
    tbl[17] = mk(0,0,0,0,0,0,   1,0,0,0,0,0,A2);
    tbl[18] = mk(1,1,0,0,0,0,   1,0,0,0,0,0,A2);
    tbl[19] = mk(1,1,0,0,0,0,   1,1,0,0,0,1,A2);
    tbl[20] = mk(1,1,0,0,0,0,   1,1,0,0,0,2,A2);
    tbl[21] = mk(1,1,0,0,0,0,   1,1,0,0,0,3,A2);
    tbl[22] = mk(1,1,1,0,0,0,   0,1,0,0,0,4,A2);
    tbl[23] = mk(0,0,0,0,0,0,   1,1,0,1,0,3,A2);
    tbl[24] = mk(0,0,1,0,0,0,   1,1,0,0,0,3,A2);
    tbl[25] = mk(0,0,1,0,0,0,   1,1,0,1,0,2,A2);
    tbl[26] = mk(0,0,1,0,0,0,   1,1,0,1,0,1,A2);
    tbl[27] = mk(0,0,0,0,0,0,   1,0,0,1,0,0,A2);
    tbl[28] = mk(0,0,1,0,1,A1,  1,0,0,0,0,0,A2);
    tbl[29] = mk(0,0,0,0,0,0,   1,0,0,0,0,0,A2);
    tbl[30] = mk(1,1,0,0,0,0,   1,0,0,0,0,0,A2);
    tbl[31] = mk(0,0,1,2,0,0,   1,1,0,0,0,1,A2);
    tbl[32] = mk(0,0,0,0,0,0,   1,0,0,!ERR_EN,ERR_EN,0,A2);
    tbl[33] = mk(0,0,0,0,0,0,   1,0,0,0,0,0,A2);

    rst_ni = 1'b1;
    drive(0,0,0,0,0,0,1);
    #2 rst_ni = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    rst_ni = 1'b1;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].rv, tbl[i].we, tbl[i].bv, tbl[i].br, tbl[i].rvl, tbl[i].rd, 1'b1);
      #2;
      chk($sformatf("row%0d ready", i),  {31'd0, req_ready_o},  {31'd0, tbl[i].e_rdy});
      chk($sformatf("row%0d bready", i), {31'd0, axi_bready_o}, {31'd0, tbl[i].e_br});
      chk($sformatf("row%0d rready", i), {31'd0, axi_rready_o}, {31'd0, tbl[i].e_rr});
      chk($sformatf("row%0d ack", i),    {31'd0, wb_ack_o},     {31'd0, tbl[i].e_ack});
      chk($sformatf("row%0d err", i),    {31'd0, wb_err_o},     {31'd0, tbl[i].e_err});
      chk($sformatf("row%0d cnt", i),    {29'd0, outstanding_o},{29'd0, tbl[i].e_cnt});
      chk($sformatf("row%0d dat", i),    wb_dat_o,              tbl[i].e_dat);
      step();
    end

    // rlast=0 protocol error, then reset with two writes pending
    drive(1,0,0,0,0,0,1); #2; step();
    drive(0,0,0,0,1,32'hCAFE0001,0); #2;
    chk("p6 rready", {31'd0, axi_rready_o}, 32'd1);
    step();
    drive(0,0,0,0,0,0,1); #2;
    chk("p6 ack", {31'd0, wb_ack_o}, 32'd1);
    chk("p6 proto set", {31'd0, proto_err_o}, 32'd1);
    chk("p6 dat", wb_dat_o, 32'hCAFE0001);
    step();
    drive(1,1,0,0,0,0,1); #2;
    chk("p6 proto sticky", {31'd0, proto_err_o}, 32'd1);
    chk("p6 ack once", {31'd0, wb_ack_o}, 32'd0);
    step();
    drive(1,1,0,0,0,0,1); #2; step();
    drive(0,0,1,0,0,0,1); #2;
    chk("p6 cnt2", {29'd0, outstanding_o}, 32'd2);
    chk("p6 bready", {31'd0, axi_bready_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    rst_ni = 1'b1;
    #2;
    chk("postrst bready", {31'd0, axi_bready_o}, 32'd0);
    chk("postrst ack0", {31'd0, wb_ack_o}, 32'd0);
    step();
    drive(0,0,0,0,0,0,1); #2;
    chk("postrst ack1", {31'd0, wb_ack_o}, 32'd0);
    chk("postrst cnt", {29'd0, outstanding_o}, 32'd0);
    step();

    // random traffic against an in-order completion queue
    q.delete();
    m_ack = 0; m_err = 0; m_proto = 0; m_dat = '0;
    for (int c = 0; c < 2000; c++) begin
      logic rv, we, bv, rvl, rl;
      logic [1:0] br, rr;
      logic [31:0] rd;
      bit can_push, pop_b, pop_r;
      rv  = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 1) == 1);
      bv  = ($urandom_range(0, 2) != 0);
      rvl = ($urandom_range(0, 2) != 0);
      br  = 2'($urandom_range(0, 3));
      rr  = 2'($urandom_range(0, 3));
      rd  = $urandom;
      rl  = ($urandom_range(0, 31) != 0);
      drive(rv, we, bv, br, rvl, rd, rl);
      axi_rresp_i = rr;
      #2;
      chk("rnd ready",  {31'd0, req_ready_o},  {31'd0, q.size() < MAXO});
      chk("rnd bready", {31'd0, axi_bready_o}, {31'd0, q.size() != 0 && q[0]});
      chk("rnd rready", {31'd0, axi_rready_o}, {31'd0, q.size() != 0 && !q[0]});
      chk("rnd cnt",    {29'd0, outstanding_o}, q.size());
      chk("rnd ack",    {31'd0, wb_ack_o},     {31'd0, m_ack});
      chk("rnd err",    {31'd0, wb_err_o},     {31'd0, m_err});
      chk("rnd dat",    wb_dat_o,              m_dat);
      chk("rnd proto",  {31'd0, proto_err_o},  {31'd0, m_proto});
      can_push = rv && (q.size() < MAXO);
      pop_b    = bv && (q.size() != 0) && q[0];
      pop_r    = rvl && (q.size() != 0) && !q[0];
      m_err    = ERR_EN && ((pop_b && br >= 2) || (pop_r && rr >= 2));
      m_ack    = (pop_b || pop_r) && !m_err;
      if (pop_r) begin
        m_dat = rd;
        if (!rl) m_proto = 1'b1;
      end
      if (pop_b || pop_r) void'(q.pop_front());
      if (can_push) q.push_back(we);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
